// File: rtl/div_seq_ctrl.sv
// Sequential 32-bit signed non-restoring divider: one quotient bit per clock, then remainder fix and sign fix-up.
// Latency: start accepted at edge E0 -> done high after E(DW+2); divide-by-zero -> done high after E1.
// Backpressure: none; start is sampled only in IDLE, ignored while busy or in DONE, never queued.
module div_seq_ctrl #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [2*DW-1:0] out
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   dvd_q,   dvd_d;      // latched dividend
    logic [DW-1:0]   dvs_q,   dvs_d;      // latched divisor
    logic [DW:0]     a_q,     a_d;        // partial remainder, signed, one guard bit
    logic [DW-1:0]   q_q,     q_d;        // quotient magnitude being built
    logic [DW:0]     m_q,     m_d;        // divisor magnitude, zero-extended
    logic            sgn_q_q, sgn_q_d;    // quotient is negative
    logic            sgn_r_q, sgn_r_d;    // remainder is negative (follows dividend)
    logic            dbz_q,   dbz_d;
    logic [2*DW-1:0] out_q,   out_d;

    logic [DW-1:0]   dvd_mag;
    logic [DW-1:0]   dvs_mag;
    logic [DW:0]     a_shift;
    logic [DW:0]     a_step;
    logic [DW:0]     a_fix;
    logic [DW-1:0]   quot;
    logic [DW-1:0]   rem;

    // Datapath: magnitudes, one non-restoring step, remainder correction, sign fix-up.
    always_comb begin
        dvd_mag = dvd_q[DW-1] ? (-dvd_q) : dvd_q;   // -(-2^31) wraps to 2^31 as unsigned, as intended
        dvs_mag = dvs_q[DW-1] ? (-dvs_q) : dvs_q;
        a_shift = {a_q[DW-1:0], q_q[DW-1]};
        a_step  = a_q[DW] ? (a_shift + m_q) : (a_shift - m_q);
        a_fix   = a_q[DW] ? (a_q + m_q) : a_q;
        quot    = sgn_q_q ? (-q_q) : q_q;
        rem     = sgn_r_q ? (-a_fix[DW-1:0]) : a_fix[DW-1:0];
    end

    // Next-state and output decode for the sequencer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        dbz_d   = dbz_q;
        out_d   = out_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    dbz_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (dvs_q == '0) begin
                    out_d   = {dvd_q, {DW{1'b1}}};
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    sgn_q_d = dvd_q[DW-1] ^ dvs_q[DW-1];
                    sgn_r_d = dvd_q[DW-1];
                    a_d     = '0;
                    q_d     = dvd_mag;
                    m_d     = {1'b0, dvs_mag};
                    count_d = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                busy    = 1'b1;
                a_d     = a_step;
                q_d     = {q_q[DW-2:0], ~a_step[DW]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(DW-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy    = 1'b1;
                a_d     = a_fix;
                out_d   = {rem, quot};
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any divide in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
            dbz_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
            dbz_q   <= dbz_d;
            out_q   <= out_d;
        end
    end

    assign div_by_zero = dbz_q;
    assign out         = out_q;

endmodule
